prescaled_event_counter: RTL and testbench
==========================================

# prescaled_event_counter

Multi-channel event counter with a per-channel programmable prescaler, wrap or saturate mode, sticky overflow flags and per-channel clear. It generalises the team's fixed two-channel counter, which had one direct counter and one divide-by-4 counter, into N identical, run-time-configurable channels. It sits beside the datapath as a statistics/profiling block: one event per cycle, steered to a channel by a select input.

## Interface
Parameters:
- W, 64: counter width per channel (≥2)
- N, 2: number of channels (≥1)
- PW, 4: prescaler divisor width

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high; clock Clk
- En  in  1  event strobe; one event per cycle when high
- Sel  in  max(1,clog2(N))  channel receiving the event
- Clear  in  N  per-channel clear, bit i clears channel i
- CfgWe  in  1  configuration write strobe
- CfgCh  in  max(1,clog2(N))  channel being configured
- CfgDiv  in  PW  divisor code d; count advances every d+1 events
- CfgSat  in  1  1 = saturate at max, 0 = wrap
- Count  out  N*W  channel i count on bits [i*W +: W]
- Ovf  out  N  sticky overflow flag per channel
- Tick  out  N  one-cycle pulse, bit i high the cycle after Count[i] changes by increment

## Operation
- Per-channel state: count (W), pre (PW), div (PW), sat (1), ovf (1), tick (1). All are registered, and outputs are driven directly from the registers.
- Event: En=1 and Sel=i with i<N. A Sel value ≥N is ignored with no state change.
- On an event, if pre==div: pre←0 and a count step occurs. Otherwise pre←pre+1.
- div=0 means every event is a count step. div=3 reproduces the legacy divide-by-4 channel.
- Count step with count<2^W−1: count←count+1, tick←1.
- Count step with count==2^W−1 and sat=0: count←0, ovf←1, tick←1.
- Count step with count==2^W−1 and sat=1: count holds, ovf←1, tick←0.
- Config write (CfgWe=1, CfgCh=i<N): div←CfgDiv, sat←CfgSat, pre←0. count and ovf are unchanged. CfgCh≥N is ignored.
- Clear[i]=1: count←0, pre←0, ovf←0, tick←0. div and sat are retained.
- Priority per channel, highest first: Reset > Clear > config write > event. A lower-priority action on the same channel in the same cycle is discarded entirely. For example, an event coinciding with a config write to the same channel is not counted.
- Actions on different channels in the same cycle are independent and all take effect.
- tick is 0 in every cycle with no count step. It is never high for two consecutive cycles unless consecutive count steps occur.
- ovf stays set until Clear or Reset.

## Timing
- Reset (synchronous): every count, pre, div, sat, ovf and tick register is cleared to 0. Count=0, Ovf=0 and Tick=0 from the edge where Reset is sampled high.
- After reset, every channel runs as a divide-by-1 wrapping counter.
- Latency: an event sampled at edge k is visible on Count and Tick after edge k, i.e. one cycle of latency.
- Config written at edge k applies to events sampled at edge k+1 onward.
- Reset asserted mid-prescale discards the partial prescale.
- Clear mid-prescale discards the partial prescale, but the divisor persists.
- Throughput: one event per cycle, sustained, with no stall.
- Only one channel can receive an event per cycle.

## Test plan
- Reset, then 5 events to channel 0 (div=0) -> Count[0]=5 after the 5th edge, Tick[0] high for 5 consecutive cycles, Count[1]=0.
- Config channel 1 with div=3, then 9 events to channel 1 -> Count[1]=2, pre[1]=1, Tick[1] pulses only after the 4th and 8th events.
- W=4, wrap mode, 17 events to channel 0 -> Count[0]=1, Ovf[0]=1 after the 16th event. Then Clear[0] -> Count[0]=0, Ovf[0]=0.
- W=4, sat=1, 20 events -> Count[0] holds at 15, Ovf[0]=1, no Tick after the 15th event.
- Same cycle: Clear[0]=1 and event on channel 0, plus CfgWe on channel 1 and En with Sel=1 (separate cycle) -> Count[0]=0, and the channel 1 event is not counted.
- Reset asserted with pre[1]=2 and Count[1]=7 -> all outputs 0 next cycle, div[1]=0, and the next channel 1 event gives Count[1]=1.

Source files
------------

// File: rtl/prescaled_event_counter.sv
// N-channel event counter with per-channel prescaler, wrap/saturate mode,
// sticky overflow and per-channel clear; all outputs come straight from registers.
module prescaled_event_counter #(
    parameter int W  = 64,
    parameter int N  = 2,
    parameter int PW = 4,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            En,
    input  logic [SW-1:0]   Sel,
    input  logic [N-1:0]    Clear,
    input  logic            CfgWe,
    input  logic [SW-1:0]   CfgCh,
    input  logic [PW-1:0]   CfgDiv,
    input  logic            CfgSat,
    output logic [N*W-1:0]  Count,
    output logic [N-1:0]    Ovf,
    output logic [N-1:0]    Tick
);

    typedef struct packed {
        logic [W-1:0] count;
        logic         ovf;
        logic         tick;
    } step_t;

    logic [W-1:0]  count_q [N];
    logic [W-1:0]  count_d [N];
    logic [PW-1:0] pre_q   [N];
    logic [PW-1:0] pre_d   [N];
    logic [PW-1:0] div_q   [N];
    logic [PW-1:0] div_d   [N];
    logic [N-1:0]  sat_q, sat_d;
    logic [N-1:0]  ovf_q, ovf_d;
    logic [N-1:0]  tick_q, tick_d;

    // One count step: increment, or at the top either wrap to 0 or hold.
    function automatic step_t count_step(input logic [W-1:0] cnt,
                                         input logic         sat,
                                         input logic         ovf);
        step_t r;
        r.count = cnt;
        r.ovf   = ovf;
        r.tick  = 1'b0;
        if (cnt != {W{1'b1}}) begin
            r.count = cnt + W'(1);
            r.tick  = 1'b1;
        end else if (!sat) begin
            r.count = '0;
            r.ovf   = 1'b1;
            r.tick  = 1'b1;
        end else begin
            r.ovf   = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        step_t s;
        s = '0;
        for (int i = 0; i < N; i++) begin
            count_d[i] = count_q[i];
            pre_d[i]   = pre_q[i];
            div_d[i]   = div_q[i];
            sat_d[i]   = sat_q[i];
            ovf_d[i]   = ovf_q[i];
            tick_d[i]  = 1'b0;
            // Clear beats config beats event; the losers are dropped entirely.
            if (Clear[i]) begin
                count_d[i] = '0;
                pre_d[i]   = '0;
                ovf_d[i]   = 1'b0;
            end else if (CfgWe && (CfgCh == SW'(i))) begin
                div_d[i] = CfgDiv;
                sat_d[i] = CfgSat;
                pre_d[i] = '0;
            end else if (En && (Sel == SW'(i))) begin
                if (pre_q[i] == div_q[i]) begin
                    pre_d[i]   = '0;
                    s          = count_step(count_q[i], sat_q[i], ovf_q[i]);
                    count_d[i] = s.count;
                    ovf_d[i]   = s.ovf;
                    tick_d[i]  = s.tick;
                end else begin
                    pre_d[i] = pre_q[i] + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < N; i++) begin
                count_q[i] <= '0;
                pre_q[i]   <= '0;
                div_q[i]   <= '0;
            end
            sat_q  <= '0;
            ovf_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                count_q[i] <= count_d[i];
                pre_q[i]   <= pre_d[i];
                div_q[i]   <= div_d[i];
            end
            sat_q  <= sat_d;
            ovf_q  <= ovf_d;
            tick_q <= tick_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_out
        assign Count[g*W +: W] = count_q[g];
    end
    assign Ovf  = ovf_q;
    assign Tick = tick_q;

endmodule

// File: tb/tb_prescaled_event_counter.sv
// Directed bench for prescaled_event_counter, built with W=4, N=3 so that
// wrap/saturate and out-of-range select are reachable in few cycles.
module tb_prescaled_event_counter;

    localparam int W  = 4;
    localparam int N  = 3;
    localparam int PW = 4;
    localparam int SW = 2;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            En;
    logic [SW-1:0]   Sel;
    logic [N-1:0]    Clear;
    logic            CfgWe;
    logic [SW-1:0]   CfgCh;
    logic [PW-1:0]   CfgDiv;
    logic            CfgSat;
    logic [N*W-1:0]  Count;
    logic [N-1:0]    Ovf;
    logic [N-1:0]    Tick;

    int tests = 0;
    int fails = 0;

    prescaled_event_counter #(.W(W), .N(N), .PW(PW)) dut (
        .Clk(Clk), .Reset(Reset), .En(En), .Sel(Sel), .Clear(Clear),
        .CfgWe(CfgWe), .CfgCh(CfgCh), .CfgDiv(CfgDiv), .CfgSat(CfgSat),
        .Count(Count), .Ovf(Ovf), .Tick(Tick)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; En = 1'b0; Sel = '0; Clear = '0;
        CfgWe = 1'b0; CfgCh = '0; CfgDiv = '0; CfgSat = 1'b0;
        tick_clk();
        tick_clk();
        chk("reset_count", 32'(Count), 32'h0);
        chk("reset_ovf",   32'(Ovf),   32'h0);
        chk("reset_tick",  32'(Tick),  32'h0);
        Reset = 1'b0;

        // Five div-by-1 events on channel 0.
        En = 1'b1; Sel = 2'd0;
        for (int k = 1; k <= 5; k++) begin
            tick_clk();
            chk("t1_count0", 32'(Count[3:0]), 32'(k));
            chk("t1_tick",   32'(Tick),       32'b001);
        end
        En = 1'b0;
        tick_clk();
        chk("t1_tick_idle", 32'(Tick),       32'h0);
        chk("t1_count1",    32'(Count[7:4]), 32'h0);

        // Channel 1 divide-by-4: steps on events 4, 8, 12.
        CfgWe = 1'b1; CfgCh = 2'd1; CfgDiv = 4'd3; CfgSat = 1'b0;
        tick_clk();
        CfgWe = 1'b0;
        chk("t2_cfg_count1", 32'(Count[7:4]), 32'h0);
        En = 1'b1; Sel = 2'd1;
        for (int k = 1; k <= 12; k++) begin
            tick_clk();
            chk("t2_count1", 32'(Count[7:4]), 32'(k / 4));
            chk("t2_tick",   32'(Tick), (k % 4 == 0) ? 32'b010 : 32'b000);
        end
        En = 1'b0;
        chk("t2_count0_kept", 32'(Count[3:0]), 32'd5);

        // Wrap mode on channel 0 after a fresh reset.
        Reset = 1'b1;
        tick_clk();
        Reset = 1'b0;
        chk("t3_reset_count", 32'(Count), 32'h0);
        En = 1'b1; Sel = 2'd0;
        for (int k = 1; k <= 17; k++) begin
            tick_clk();
            chk("t3_count0", 32'(Count[3:0]), 32'(k % 16));
            chk("t3_ovf0",   32'(Ovf[0]),     (k >= 16) ? 32'h1 : 32'h0);
            chk("t3_tick0",  32'(Tick[0]),    32'h1);
        end
        En = 1'b0; Clear = 3'b001;
        tick_clk();
        Clear = '0;
        chk("t3_clr_count0", 32'(Count[3:0]), 32'h0);
        chk("t3_clr_ovf0",   32'(Ovf[0]),     32'h0);
        chk("t3_clr_tick",   32'(Tick),       32'h0);

        // Saturate mode on channel 0.
        CfgWe = 1'b1; CfgCh = 2'd0; CfgDiv = 4'd0; CfgSat = 1'b1;
        tick_clk();
        CfgWe = 1'b0;
        En = 1'b1; Sel = 2'd0;
        for (int k = 1; k <= 20; k++) begin
            tick_clk();
            chk("t4_count0", 32'(Count[3:0]), (k < 15) ? 32'(k) : 32'd15);
            chk("t4_ovf0",   32'(Ovf[0]),     (k >= 16) ? 32'h1 : 32'h0);
            chk("t4_tick0",  32'(Tick[0]),    (k <= 15) ? 32'h1 : 32'h0);
        end
        En = 1'b0; Clear = 3'b001;
        tick_clk();
        Clear = '0;
        chk("t4_clr_ovf0", 32'(Ovf[0]), 32'h0);

        // Clear wins over a same-cycle event on channel 0.
        En = 1'b1; Sel = 2'd0;
        tick_clk();
        tick_clk();
        chk("t5_pre_count0", 32'(Count[3:0]), 32'd2);
        Clear = 3'b001;
        tick_clk();
        Clear = '0; En = 1'b0;
        chk("t5_clr_count0", 32'(Count[3:0]), 32'h0);
        chk("t5_clr_tick",   32'(Tick),       32'h0);

        // Config write on channel 1 swallows a channel-1 event.
        CfgWe = 1'b1; CfgCh = 2'd1; CfgDiv = 4'd0; CfgSat = 1'b0;
        En = 1'b1; Sel = 2'd1;
        tick_clk();
        chk("t5_cfg_count1", 32'(Count[7:4]), 32'h0);
        chk("t5_cfg_tick",   32'(Tick),       32'h0);
        // Config on channel 1 and event on channel 0 are independent.
        Sel = 2'd0;
        tick_clk();
        CfgWe = 1'b0;
        chk("t5_indep_count0", 32'(Count[3:0]), 32'd1);
        chk("t5_indep_tick",   32'(Tick),       32'b001);
        // Sel beyond N is ignored.
        Sel = 2'd3;
        tick_clk();
        chk("t5_sel3_count", 32'(Count), 32'h001);
        chk("t5_sel3_tick",  32'(Tick),  32'h0);

        // Reset mid-prescale: channel 1 at count 7, pre 2.
        Sel = 2'd1;
        for (int k = 0; k < 7; k++) tick_clk();
        En = 1'b0;
        chk("t6_count1_7", 32'(Count[7:4]), 32'd7);
        CfgWe = 1'b1; CfgCh = 2'd1; CfgDiv = 4'd3; CfgSat = 1'b0;
        tick_clk();
        CfgWe = 1'b0;
        chk("t6_cfg_keeps_count1", 32'(Count[7:4]), 32'd7);
        En = 1'b1; Sel = 2'd1;
        tick_clk();
        tick_clk();
        chk("t6_prescale_count1", 32'(Count[7:4]), 32'd7);
        chk("t6_prescale_tick",   32'(Tick),       32'h0);
        En = 1'b0; Reset = 1'b1;
        tick_clk();
        Reset = 1'b0;
        chk("t6_reset_count", 32'(Count), 32'h0);
        chk("t6_reset_ovf",   32'(Ovf),   32'h0);
        chk("t6_reset_tick",  32'(Tick),  32'h0);
        En = 1'b1; Sel = 2'd1;
        tick_clk();
        En = 1'b0;
        chk("t6_after_count1", 32'(Count[7:4]), 32'd1);
        chk("t6_after_tick",   32'(Tick),       32'b010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
